// File: rtl/mii_pkg.sv
// Shared MII receive definitions.
// Holds the preamble/SFD nibble values as seen on RXD and the
// receive framer state encoding.
package mii_pkg;

    localparam logic [3:0] MII_PREAMBLE_NIB = 4'h5;
    localparam logic [3:0] MII_SFD_NIB      = 4'hD;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        DATA     = 2'd2,
        DROP     = 2'd3
    } framer_state_t;

endpackage

// File: rtl/mii_nibble_packer.sv
// Nibble -> byte -> OUT_BYTES-wide word packer for the MII receive framer.
// Ports:
//   mii_clk, reset : clock and synchronous active-high reset
//   nib_valid      : accept nib this edge (payload nibble, RX_DV high)
//   nib            : payload nibble, low nibble of each byte first
//   nib_er         : RX_ER sampled with this nibble (sticky frame error)
//   frame_end      : RX_DV fell while receiving payload; close the frame
//   out_*          : registered beat outputs (valid/data/keep/sof/eof/err)
// A completed word parks in a one-deep hold register and is emitted on the
// next edge; whether that beat is the eof beat depends on frame_end there.
module mii_nibble_packer #(
    parameter int OUT_BYTES = 1
) (
    input  logic                   mii_clk,
    input  logic                   reset,
    input  logic                   nib_valid,
    input  logic [3:0]             nib,
    input  logic                   nib_er,
    input  logic                   frame_end,
    output logic                   out_valid,
    output logic [8*OUT_BYTES-1:0] out_data,
    output logic [OUT_BYTES-1:0]   out_keep,
    output logic                   out_sof,
    output logic                   out_eof,
    output logic                   out_err
);

    localparam int WORD_W = 8 * OUT_BYTES;
    localparam int CNT_W  = (OUT_BYTES > 1) ? $clog2(OUT_BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(OUT_BYTES - 1);

    logic [3:0]        low_nib_reg;
    logic              nib_pending_reg;
    logic [CNT_W-1:0]  byte_cnt_reg;
    logic [WORD_W-1:0] word_reg;
    logic [WORD_W-1:0] hold_reg;
    logic              hold_valid_reg;
    logic              err_reg;
    logic              beat_sent_reg;   // a beat of the current frame already left

    logic [7:0]           new_byte;
    logic [WORD_W-1:0]    word_done;
    logic [OUT_BYTES-1:0] partial_keep;

    assign new_byte = {nib, low_nib_reg};

    // Word as it looks once the top byte lane is filled by new_byte.
    always_comb begin
        word_done = word_reg;
        word_done[8*(OUT_BYTES-1) +: 8] = new_byte;
    end

    // Keep mask for a partial word: lanes below the completed-byte count.
    genvar gi;
    generate
        for (gi = 0; gi < OUT_BYTES; gi = gi + 1) begin : g_keep
            assign partial_keep[gi] = (32'(byte_cnt_reg) > gi);
        end
    endgenerate

    always_ff @(posedge mii_clk) begin
        if (reset) begin
            low_nib_reg     <= '0;
            nib_pending_reg <= 1'b0;
            byte_cnt_reg    <= '0;
            word_reg        <= '0;
            hold_reg        <= '0;
            hold_valid_reg  <= 1'b0;
            err_reg         <= 1'b0;
            beat_sent_reg   <= 1'b0;
            out_valid       <= 1'b0;
            out_data        <= '0;
            out_keep        <= '0;
            out_sof         <= 1'b0;
            out_eof         <= 1'b0;
            out_err         <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_keep  <= '0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
            out_err   <= 1'b0;

            if (hold_valid_reg) begin
                // A held word and a partial word cannot coexist at frame end,
                // so the hold path alone covers the eof case here.
                out_valid      <= 1'b1;
                out_data       <= hold_reg;
                out_keep       <= '1;
                out_sof        <= ~beat_sent_reg;
                out_eof        <= frame_end;
                out_err        <= frame_end & err_reg;
                hold_valid_reg <= 1'b0;
                beat_sent_reg  <= 1'b1;
            end else if (frame_end && ((byte_cnt_reg != '0) || nib_pending_reg)) begin
                // Partial word and/or dangling nibble. With no complete byte,
                // word_reg and partial_keep are both zero, giving the keep=0 beat.
                out_valid <= 1'b1;
                out_data  <= word_reg;
                out_keep  <= partial_keep;
                out_sof   <= ~beat_sent_reg;
                out_eof   <= 1'b1;
                out_err   <= err_reg | nib_pending_reg;
            end

            if (frame_end) begin
                nib_pending_reg <= 1'b0;
                byte_cnt_reg    <= '0;
                word_reg        <= '0;
                err_reg         <= 1'b0;
                beat_sent_reg   <= 1'b0;
            end else if (nib_valid) begin
                if (nib_er) begin
                    err_reg <= 1'b1;
                end
                if (!nib_pending_reg) begin
                    low_nib_reg     <= nib;
                    nib_pending_reg <= 1'b1;
                end else begin
                    nib_pending_reg <= 1'b0;
                    if (byte_cnt_reg == LAST_BYTE) begin
                        hold_reg       <= word_done;
                        hold_valid_reg <= 1'b1;
                        byte_cnt_reg   <= '0;
                        word_reg       <= '0;
                    end else begin
                        word_reg[8*byte_cnt_reg +: 8] <= new_byte;
                        byte_cnt_reg <= byte_cnt_reg + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/mii_rx_framer.sv
// MII receive framer: hunts preamble/SFD (optional), assembles payload
// nibbles into OUT_BYTES-wide words and marks sof/eof/err on the beats.
// Ports:
//   mii_clk, reset : receive clock, synchronous active-high reset
//   mii_en, mii_er : RX_DV / RX_ER from the PHY
//   mii_d          : RXD nibble, low nibble of each byte first
//   out_valid      : one-cycle beat strobe
//   out_data       : payload word, byte 0 in [7:0] is earliest on the wire
//   out_keep       : per-byte valid mask, contiguous from bit 0
//   out_sof/eof    : first/last beat of frame, qualified by out_valid
//   out_err        : frame error, meaningful on the eof beat
module mii_rx_framer
    import mii_pkg::*;
#(
    parameter int OUT_BYTES      = 1,
    parameter int STRIP_PREAMBLE = 1
) (
    input  logic                   mii_clk,
    input  logic                   reset,
    input  logic                   mii_en,
    input  logic                   mii_er,
    input  logic [3:0]             mii_d,
    output logic                   out_valid,
    output logic [8*OUT_BYTES-1:0] out_data,
    output logic [OUT_BYTES-1:0]   out_keep,
    output logic                   out_sof,
    output logic                   out_eof,
    output logic                   out_err
);

    framer_state_t state_reg, state_next, hunt_next;
    logic          after_reset_reg;   // first edge after reset not yet seen
    logic          nib_valid;
    logic          frame_end;

    always_ff @(posedge mii_clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            after_reset_reg <= 1'b1;
        end else begin
            state_reg       <= state_next;
            after_reset_reg <= 1'b0;
        end
    end

    always_comb begin
        state_next = state_reg;
        nib_valid  = 1'b0;
        frame_end  = 1'b0;

        // Preamble hunting decision for the nibble on this edge; shared by
        // IDLE (burst start consumes its first nibble) and PREAMBLE.
        if (mii_er) begin
            hunt_next = DROP;
        end else if (mii_d == MII_PREAMBLE_NIB) begin
            hunt_next = PREAMBLE;
        end else if (mii_d == MII_SFD_NIB) begin
            hunt_next = DATA;
        end else begin
            hunt_next = DROP;
        end

        case (state_reg)
            IDLE: begin
                if (mii_en) begin
                    if (after_reset_reg) begin
                        // RX_DV already high out of reset: mid-frame, skip it.
                        state_next = DROP;
                    end else if (STRIP_PREAMBLE != 0) begin
                        state_next = hunt_next;
                    end else begin
                        state_next = DATA;
                        nib_valid  = 1'b1;
                    end
                end
            end
            PREAMBLE: begin
                if (!mii_en) begin
                    state_next = IDLE;
                end else begin
                    state_next = hunt_next;
                end
            end
            DATA: begin
                if (mii_en) begin
                    nib_valid = 1'b1;
                end else begin
                    frame_end  = 1'b1;
                    state_next = IDLE;
                end
            end
            DROP: begin
                if (!mii_en) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    mii_nibble_packer #(
        .OUT_BYTES(OUT_BYTES)
    ) u_packer (
        .mii_clk   (mii_clk),
        .reset     (reset),
        .nib_valid (nib_valid),
        .nib       (mii_d),
        .nib_er    (mii_er),
        .frame_end (frame_end),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_keep  (out_keep),
        .out_sof   (out_sof),
        .out_eof   (out_eof),
        .out_err   (out_err)
    );

endmodule

// File: tb/tb_mii_rx_framer.sv
// Testbench for mii_rx_framer: three instances (OUT_BYTES 1, 2, 4) share
// one MII stimulus stream. Each frame is turned into expected beats by a
// frame-level reference model and queued; a monitor pops and compares.
module tb_mii_rx_framer;

    logic       mii_clk = 1'b0;
    logic       reset   = 1'b1;
    logic       mii_en  = 1'b0;
    logic       mii_er  = 1'b0;
    logic [3:0] mii_d   = 4'h0;

    always #5 mii_clk = ~mii_clk;

    logic        v1, s1, e1, r1;
    logic [7:0]  d1;
    logic [0:0]  k1;
    logic        v2, s2, e2, r2;
    logic [15:0] d2;
    logic [1:0]  k2;
    logic        v4, s4, e4, r4;
    logic [31:0] d4;
    logic [3:0]  k4;

    mii_rx_framer #(.OUT_BYTES(1), .STRIP_PREAMBLE(1)) u_dut1 (
        .mii_clk(mii_clk), .reset(reset), .mii_en(mii_en), .mii_er(mii_er), .mii_d(mii_d),
        .out_valid(v1), .out_data(d1), .out_keep(k1), .out_sof(s1), .out_eof(e1), .out_err(r1));
    mii_rx_framer #(.OUT_BYTES(2), .STRIP_PREAMBLE(1)) u_dut2 (
        .mii_clk(mii_clk), .reset(reset), .mii_en(mii_en), .mii_er(mii_er), .mii_d(mii_d),
        .out_valid(v2), .out_data(d2), .out_keep(k2), .out_sof(s2), .out_eof(e2), .out_err(r2));
    mii_rx_framer #(.OUT_BYTES(4), .STRIP_PREAMBLE(1)) u_dut4 (
        .mii_clk(mii_clk), .reset(reset), .mii_en(mii_en), .mii_er(mii_er), .mii_d(mii_d),
        .out_valid(v4), .out_data(d4), .out_keep(k4), .out_sof(s4), .out_eof(e4), .out_err(r4));

    // cyc equals the index of the most recent rising edge.
    int cyc = 0;
    always @(posedge mii_clk) cyc <= cyc + 1;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        sof;
        logic        eof;
        logic        err;
        int          cyc;
    } beat_t;

    beat_t q1[$];
    beat_t q2[$];
    beat_t q4[$];

    logic [3:0] f_nib[$];
    logic       f_er[$];

    function automatic int lane_bytes(input int k);
        return (k == 0) ? 1 : (k == 1) ? 2 : 4;
    endfunction

    task automatic push_exp(input int k, input beat_t b);
        case (k)
            0: q1.push_back(b);
            1: q2.push_back(b);
            default: q4.push_back(b);
        endcase
    endtask

    // Frame-level reference: find SFD after a run of 0x5 nibbles (any error
    // or foreign nibble first drops the frame), then slice the payload into
    // bytes and words. Each beat appears one edge after its last nibble.
    task automatic model_frame(input int k, input int start);
        int    nb, n, ps, p, nbytes, odd, nw, rem, idx;
        logic  sticky, first;
        beat_t b;
        nb = lane_bytes(k);
        n  = f_nib.size();
        ps = -1;
        for (int i = 0; i < n; i++) begin
            if (f_er[i])                  begin ps = -2;    break; end
            if (f_nib[i] == 4'hD)         begin ps = i + 1; break; end
            if (f_nib[i] != 4'h5)         begin ps = -2;    break; end
        end
        if (ps < 0) return;
        p      = n - ps;
        nbytes = p / 2;
        odd    = p % 2;
        sticky = 1'b0;
        for (int i = ps; i < n; i++) sticky = sticky | f_er[i];
        nw    = nbytes / nb;
        rem   = nbytes % nb;
        first = 1'b1;
        for (int w = 0; w < nw; w++) begin
            b.data = '0;
            for (int j = 0; j < nb; j++) begin
                idx = ps + 2 * (w * nb + j);
                b.data[8*j +: 8] = {f_nib[idx+1], f_nib[idx]};
            end
            b.keep = 4'((1 << nb) - 1);
            b.sof  = first;
            b.eof  = (w == nw - 1) && (rem == 0) && (odd == 0);
            b.err  = b.eof ? sticky : 1'b0;
            b.cyc  = start + ps + 2 * (w + 1) * nb;
            first  = 1'b0;
            push_exp(k, b);
        end
        if (rem > 0 || odd > 0) begin
            b.data = '0;
            for (int j = 0; j < rem; j++) begin
                idx = ps + 2 * (nw * nb + j);
                b.data[8*j +: 8] = {f_nib[idx+1], f_nib[idx]};
            end
            b.keep = 4'((1 << rem) - 1);
            b.sof  = first;
            b.eof  = 1'b1;
            b.err  = sticky | (odd != 0);
            b.cyc  = start + n;
            push_exp(k, b);
        end
    endtask

    task automatic check_beat(input int k, input logic [31:0] d, input logic [3:0] kp,
                              input logic s, input logic e, input logic r);
        beat_t x;
        int    sz;
        bit    ok;
        tests_run++;
        sz = (k == 0) ? q1.size() : (k == 1) ? q2.size() : q4.size();
        if (sz == 0) begin
            tests_failed++;
            $display("FAIL beat_ob%0d: got data=%h keep=%h sof=%0d eof=%0d at cycle %0d, required no beat",
                     lane_bytes(k), d, kp, s, e, cyc);
            return;
        end
        case (k)
            0: x = q1.pop_front();
            1: x = q2.pop_front();
            default: x = q4.pop_front();
        endcase
        ok = (d == x.data) && (kp == x.keep) && (s == x.sof) && (e == x.eof) &&
             (!x.eof || (r == x.err)) && (cyc == x.cyc);
        if (!ok) begin
            tests_failed++;
            $display("FAIL beat_ob%0d: got data=%h keep=%h sof=%0d eof=%0d err=%0d cyc=%0d, required data=%h keep=%h sof=%0d eof=%0d err=%0d cyc=%0d",
                     lane_bytes(k), d, kp, s, e, r, cyc, x.data, x.keep, x.sof, x.eof, x.err, x.cyc);
        end else begin
            $display("[TB] ob=%0d beat data=%h keep=%h sof=%0d eof=%0d err=%0d cyc=%0d ok",
                     lane_bytes(k), d, kp, s, e, r, cyc);
        end
    endtask

    // Monitor: every presented beat is matched against the scoreboard.
    always @(negedge mii_clk) begin
        if (v1) check_beat(0, 32'(d1), 4'(k1), s1, e1, r1);
        if (v2) check_beat(1, 32'(d2), 4'(k2), s2, e2, r2);
        if (v4) check_beat(2, d4, k4, s4, e4, r4);
    end

    task automatic check_idle(input string name);
        tests_run++;
        if ({v1, s1, e1, r1, d1, k1, v2, s2, e2, r2, d2, k2, v4, s4, e4, r4, d4, k4} != '0) begin
            tests_failed++;
            $display("FAIL %s: got valid=%0d%0d%0d data=%h/%h/%h keep=%h/%h/%h sof=%0d%0d%0d eof=%0d%0d%0d, required all 0",
                     name, v1, v2, v4, d1, d2, d4, k1, k2, k4, s1, s2, s4, e1, e2, e4);
        end
    endtask

    task automatic clear_frame();
        f_nib.delete();
        f_er.delete();
    endtask

    task automatic add_nib(input logic [3:0] n, input logic e);
        f_nib.push_back(n);
        f_er.push_back(e);
    endtask

    task automatic add_byte(input logic [7:0] b, input logic e);
        add_nib(b[3:0], e);
        add_nib(b[7:4], 1'b0);
    endtask

    task automatic add_pre(input int n);
        for (int i = 0; i < n; i++) add_nib(4'h5, 1'b0);
        add_nib(4'hD, 1'b0);
    endtask

    // Drive the built frame with RX_DV high, then hold RX_DV low for gap cycles.
    task automatic send_frame(input int gap);
        int start, n;
        n = f_nib.size();
        @(negedge mii_clk);
        start = cyc + 1;
        for (int k = 0; k < 3; k++) model_frame(k, start);
        for (int i = 0; i < n; i++) begin
            mii_en = 1'b1;
            mii_d  = f_nib[i];
            mii_er = f_er[i];
            if (i != n - 1) @(negedge mii_clk);
        end
        for (int g = 0; g < gap; g++) begin
            @(negedge mii_clk);
            mii_en = 1'b0;
            mii_er = 1'b0;
            mii_d  = 4'($urandom);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int pre_len, pay_len;
        // Reset with RX_DV low.
        repeat (3) begin
            @(negedge mii_clk);
            check_idle("reset_state");
        end
        reset = 1'b0;
        repeat (3) @(negedge mii_clk);

        // Two bytes on a 1-byte bus.
        clear_frame(); add_pre(15);
        add_nib(4'h1, 0); add_nib(4'h2, 0); add_nib(4'h3, 0); add_nib(4'h4, 0);
        send_frame(2);

        // Six bytes: full word then partial.
        clear_frame(); add_pre(7);
        for (int i = 1; i <= 6; i++) add_byte(8'(i * 8'h11), 0);
        send_frame(1);

        // Four bytes: eof on the held word.
        clear_frame(); add_pre(2);
        add_byte(8'hAA, 0); add_byte(8'hBB, 0); add_byte(8'hCC, 0); add_byte(8'hDD, 0);
        send_frame(1);

        // Byte plus dangling nibble.
        clear_frame(); add_pre(7); add_byte(8'h5A, 0); add_nib(4'h7, 0);
        send_frame(1);

        // RX_ER mid-payload.
        clear_frame(); add_pre(7);
        add_byte(8'h12, 0); add_byte(8'h34, 1); add_byte(8'h56, 0);
        send_frame(1);

        // Bad preamble nibble: dropped, then a clean frame.
        clear_frame(); add_nib(4'h5, 0); add_nib(4'h3, 0); add_pre(3); add_byte(8'h99, 0);
        send_frame(1);
        clear_frame(); add_pre(7); add_byte(8'hC3, 0); add_byte(8'h3C, 0);
        send_frame(1);

        // SFD with no payload, then SFD with only one nibble.
        clear_frame(); add_pre(7);
        send_frame(1);
        clear_frame(); add_pre(7); add_nib(4'hE, 0);
        send_frame(1);

        // Reset mid-payload with RX_DV held high.
        clear_frame(); add_pre(7); add_nib(4'h1, 0); add_nib(4'h1, 0);
        for (int i = 0; i < f_nib.size(); i++) begin
            @(negedge mii_clk);
            mii_en = 1'b1; mii_d = f_nib[i]; mii_er = 1'b0;
        end
        @(negedge mii_clk);
        reset = 1'b1; mii_d = 4'h5;
        @(negedge mii_clk);
        check_idle("reset_mid_frame");
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge mii_clk);
            if (i > 0) check_idle("drop_after_reset");
            mii_d = (i == 3) ? 4'hD : (i < 3) ? 4'h5 : 4'(i);
        end
        @(negedge mii_clk);
        check_idle("drop_after_reset");
        mii_en = 1'b0;
        @(negedge mii_clk);
        check_idle("drop_after_reset");
        clear_frame(); add_pre(7); add_byte(8'h81, 0); add_byte(8'h42, 0); add_byte(8'h24, 0);
        send_frame(1);

        // Randomized frames, mostly clean with occasional errors/bad preambles.
        for (int f = 0; f < 40; f++) begin
            clear_frame();
            pre_len = $urandom_range(0, 15);
            for (int i = 0; i < pre_len; i++) begin
                if ($urandom_range(0, 39) == 0) add_nib(4'($urandom), 0);
                else add_nib(4'h5, ($urandom_range(0, 79) == 0));
            end
            add_nib(4'hD, 0);
            pay_len = $urandom_range(0, 24);
            for (int i = 0; i < pay_len; i++) add_nib(4'($urandom), ($urandom_range(0, 19) == 0));
            send_frame($urandom_range(1, 3));
        end

        repeat (5) @(negedge mii_clk);
        for (int k = 0; k < 3; k++) begin
            int sz;
            sz = (k == 0) ? q1.size() : (k == 1) ? q2.size() : q4.size();
            tests_run++;
            if (sz != 0) begin
                tests_failed++;
                $display("FAIL missing_beats_ob%0d: got %0d beats still expected, required 0",
                         lane_bytes(k), sz);
            end
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mii_rx_framer.md
Name: mii_rx_framer

Overview:
Parametrised MII receive framer; successor to the team's plain nibble-to-byte MII receiver.
- Detects preamble/SFD and strips it (optional).
- Assembles low-nibble-first nibbles into bytes, then packs bytes into OUT_BYTES-wide words.
- Marks start/end of frame with a byte-keep mask and an error flag.
- Sits between the PHY MII RX pins and the MAC RX datapath, entirely in the mii_clk domain, with no backpressure.

Parameters:
- OUT_BYTES, default 1: bytes per output word; legal values 1, 2, 4.
- STRIP_PREAMBLE, default 1: 1 = hunt for preamble/SFD and drop it; 0 = first nibble of the mii_en burst is payload.

Ports:
- mii_clk  in  1  receive clock (2.5/25 MHz).
- reset  in  1  reset, synchronous, active-high.
- mii_en  in  1  RX_DV from PHY.
- mii_er  in  1  RX_ER from PHY.
- mii_d  in  4  RXD nibble; low nibble of each byte arrives first.
- out_valid  out  1  one-cycle beat strobe.
- out_data  out  8*OUT_BYTES  packed payload; byte 0 at bits [7:0] is earliest on the wire.
- out_keep  out  OUT_BYTES  per-byte valid mask; contiguous from bit 0.
- out_sof  out  1  first beat of frame; qualified by out_valid.
- out_eof  out  1  last beat of frame; qualified by out_valid.
- out_err  out  1  frame error; meaningful only on the eof beat.

Behaviour:
- Reset: every output is 0, state goes to IDLE, the pending nibble/byte/hold registers are cleared, and the sticky error flag is cleared.
- All inputs are sampled on posedge mii_clk; all outputs are registered.
- States:
  - IDLE: en=1 -> PREAMBLE if STRIP_PREAMBLE, else DATA; the nibble sampled on that edge is consumed by the target state.
  - PREAMBLE:
    - nibble 0x5 -> stay.
    - nibble 0xD -> DATA; the SFD nibble is not payload.
    - any other nibble, or er=1 -> DROP.
    - en=0 -> IDLE.
    - No beats are emitted in this state.
  - DATA: nibble assembly and packing; en=0 -> IDLE after end-of-frame handling.
  - DROP: ignore everything until en=0 -> IDLE. No beats are emitted.
  - After reset, if en=1 on the first sampled edge -> DROP, so reception never starts mid-frame.
- Nibble/byte rules in DATA:
  - The first nibble of each byte fills byte[3:0]; the second fills byte[7:4].
  - When byte OUT_BYTES-1 completes, the word moves to a one-deep hold register at edge N.
- Hold emission:
  - The hold register is always emitted at edge N+1, with out_valid=1 and out_keep all-ones.
  - Its eof flag is decided by mii_en sampled at N+1: en=0 means out_eof=1.
  - Latency: a completed word is visible one cycle after its final nibble edge.
- out_sof: 1 on the first beat after SFD (or after frame start when STRIP_PREAMBLE=0), else 0.
- End of frame (en falls while in DATA), exactly one eof beat:
  - Hold pending: emit hold with eof.
  - Partial word pending (1..OUT_BYTES-1 bytes): emit it with keep = low k bits set, unused bytes 0, eof=1.
  - Only a dangling low nibble pending: emit beat with keep=0, data=0, eof=1, err=1. The nibble is discarded.
  - Partial bytes plus a dangling nibble: partial beat with err=1.
  - No payload byte or nibble received since SFD: no beat at all.
- out_err on the eof beat = OR of the sticky er (mii_er=1 on any edge in DATA with en=1) and the odd-nibble condition.
- Structural guarantees:
  - The hold register and a partial word never coexist at en fall.
  - A beat can be both sof and eof.
- Reset mid-frame: outputs clear immediately on the reset edge; no eof beat is produced for the aborted frame.
- Back-to-back frames: en low for one cycle is sufficient. The eof beat of frame k and the first nibble of frame k+1 do not interact.

Decomposition:
- Shared package mii_pkg holds:
  - Constants: MII_PREAMBLE_NIB=4'h5, MII_SFD_NIB=4'hD.
  - Framer state enum: IDLE/PREAMBLE/DATA/DROP.
- One natural sub-module, mii_nibble_packer: nibble -> byte -> OUT_BYTES word packer with the hold register and keep generation. The FSM stays in mii_rx_framer.

Test Plan:
- OUT_BYTES=1, STRIP=1; en=1 for nibbles 5×15, D, then 1,2 and 3,4 -> two beats: 0x21 (sof=1), then 0x43 (eof=1, err=0); each beat 1 cycle after its high nibble.
- OUT_BYTES=4; preamble+SFD, then 6 bytes 0x11..0x66 -> beat1 data 0x44332211 keep 4'hF sof=1; beat2 data 0x00006655 keep 4'h3 eof=1.
- OUT_BYTES=2; SFD then 4 bytes 0xAA,0xBB,0xCC,0xDD -> beat1 0xBBAA keep 2'b11 sof=1; beat2 0xDDCC keep 2'b11 eof=1 (hold-register eof path).
- OUT_BYTES=1; SFD, byte 0x5A, one extra nibble 0x7, en=0 -> beat 0x5A sof=1 eof=0, then beat keep=0 eof=1 err=1.
- mii_er=1 for one cycle mid-payload -> eof beat err=1. Preamble nibble 0x3 -> DROP, no beats until en falls; next clean frame is received normally.
- Reset asserted mid-payload with OUT_BYTES=4 and en still high -> all outputs 0, DROP until en=0, no spurious eof; the following frame starts with sof=1.
